// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register for the pipelined MIPS core.
// Holds the fetched instruction and PC+4 for the decode stage.
// Stall freezes the stage and Flush squashes it into a bubble.
// Saturating stall/flush event counters and a sticky stall watchdog are
// included for debug visibility.
module if_id_pipe_reg #(
    parameter int               DATA_W    = 32,
    parameter logic [DATA_W-1:0] NOP_INSTR = 32'h00000000,
    parameter int               CNT_W     = 16,
    parameter int               MAX_STALL = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [DATA_W-1:0] Instruction_in,
    input  logic [DATA_W-1:0] PCPlus4_in,
    input  logic              Stall,
    input  logic              Flush,
    output logic [DATA_W-1:0] Instruction_out,
    output logic [DATA_W-1:0] PCPlus4_out,
    output logic              Valid_out,
    output logic [CNT_W-1:0]  StallCount,
    output logic [CNT_W-1:0]  FlushCount,
    output logic              StallTimeout
);

    // The run counter must be able to hold MAX_STALL itself, since it
    // saturates there rather than wrapping.
    localparam int               RUN_W   = $clog2(MAX_STALL + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);

    typedef enum logic [1:0] {
        MODE_LOAD  = 2'd0,
        MODE_STALL = 2'd1,
        MODE_FLUSH = 2'd2
    } mode_t;

    mode_t            mode;
    logic [RUN_W-1:0] run_cnt;
    logic [RUN_W-1:0] run_cnt_next;

    // Resolve the per-edge mode: flush beats stall, and stall beats load.
    always_comb begin
        mode = MODE_LOAD;
        if (Flush) begin
            mode = MODE_FLUSH;
        end else if (Stall) begin
            mode = MODE_STALL;
        end
    end

    // Next value of the consecutive-stall run counter.
    // Only an uninterrupted stall advances it; it stops at MAX_STALL.
    always_comb begin
        run_cnt_next = '0;
        if (mode == MODE_STALL) begin
            if (run_cnt == RUN_MAX) begin
                run_cnt_next = RUN_MAX;
            end else begin
                run_cnt_next = run_cnt + RUN_W'(1);
            end
        end
    end

    // Pipeline payload: capture on load, squash to a NOP on flush, and keep
    // the current contents on stall. A held bubble therefore stays a bubble.
    // PC+4 is still captured on flush so decode sees where the bubble sits.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Instruction_out <= NOP_INSTR;
            PCPlus4_out     <= '0;
            Valid_out       <= 1'b0;
        end else begin
            case (mode)
                MODE_FLUSH: begin
                    Instruction_out <= NOP_INSTR;
                    PCPlus4_out     <= PCPlus4_in;
                    Valid_out       <= 1'b0;
                end
                MODE_LOAD: begin
                    Instruction_out <= Instruction_in;
                    PCPlus4_out     <= PCPlus4_in;
                    Valid_out       <= 1'b1;
                end
                default: begin
                    Instruction_out <= Instruction_out;
                    PCPlus4_out     <= PCPlus4_out;
                    Valid_out       <= Valid_out;
                end
            endcase
        end
    end

    // Event counters for stalled and flushed edges.
    // They saturate at all-ones so a long run never reads back as small.
    // A combined flush+stall edge counts only as a flush.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (mode == MODE_STALL && StallCount != {CNT_W{1'b1}}) begin
                StallCount <= StallCount + CNT_W'(1);
            end
            if (mode == MODE_FLUSH && FlushCount != {CNT_W{1'b1}}) begin
                FlushCount <= FlushCount + CNT_W'(1);
            end
        end
    end

    // Stall watchdog: track the current run of consecutive stall edges.
    // StallTimeout latches on the edge where the run reaches MAX_STALL and
    // stays set until reset.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            run_cnt      <= '0;
            StallTimeout <= 1'b0;
        end else begin
            run_cnt <= run_cnt_next;
            if (mode == MODE_STALL && run_cnt_next == RUN_MAX) begin
                StallTimeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Self-checking bench for the IF/ID pipeline register.
// A table of directed vectors covers load/stall/flush behaviour.
// Hand-written sequences cover the watchdog, async reset and counter
// saturation, which is checked on a second instance built with CNT_W=4.
module tb_if_id_pipe_reg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;
    localparam logic [31:0] NOP = 32'h00000000;

    logic              Clk;
    logic              Rst;
    logic [DATA_W-1:0] Instruction_in;
    logic [DATA_W-1:0] PCPlus4_in;
    logic              Stall;
    logic              Flush;
    logic [DATA_W-1:0] Instruction_out;
    logic [DATA_W-1:0] PCPlus4_out;
    logic              Valid_out;
    logic [CNT_W-1:0]  StallCount;
    logic [CNT_W-1:0]  FlushCount;
    logic              StallTimeout;

    logic [DATA_W-1:0] small_instr;
    logic [DATA_W-1:0] small_pc;
    logic              small_valid;
    logic [3:0]        small_scnt;
    logic [3:0]        small_fcnt;
    logic              small_to;

    int total;
    int bad;

    if_id_pipe_reg #(
        .DATA_W(DATA_W), .NOP_INSTR(32'h00000000), .CNT_W(CNT_W), .MAX_STALL(8)
    ) dut (
        .Clk(Clk), .Rst(Rst),
        .Instruction_in(Instruction_in), .PCPlus4_in(PCPlus4_in),
        .Stall(Stall), .Flush(Flush),
        .Instruction_out(Instruction_out), .PCPlus4_out(PCPlus4_out),
        .Valid_out(Valid_out), .StallCount(StallCount),
        .FlushCount(FlushCount), .StallTimeout(StallTimeout)
    );

    if_id_pipe_reg #(
        .DATA_W(DATA_W), .NOP_INSTR(32'h00000000), .CNT_W(4), .MAX_STALL(8)
    ) dut_small (
        .Clk(Clk), .Rst(Rst),
        .Instruction_in(Instruction_in), .PCPlus4_in(PCPlus4_in),
        .Stall(Stall), .Flush(Flush),
        .Instruction_out(small_instr), .PCPlus4_out(small_pc),
        .Valid_out(small_valid), .StallCount(small_scnt),
        .FlushCount(small_fcnt), .StallTimeout(small_to)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        stall;
        logic        flush;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;
        logic        exp_valid;
        logic [15:0] exp_scnt;
        logic [15:0] exp_fcnt;
        logic        exp_to;
    } vec_t;

    vec_t vecs[9];

    // Free-running clock, 10 time units per cycle.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Hard stop in case anything ever stalls the stimulus thread.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    // Drive one edge worth of inputs, then settle just after the edge.
    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                                 input logic stall, input logic flush);
        Instruction_in = instr;
        PCPlus4_in     = pc;
        Stall          = stall;
        Flush          = flush;
        @(posedge Clk);
        #1;
    endtask

    // Compare every output of the main instance against expected values.
    task automatic checkOutput(input string name, input logic [31:0] e_instr,
                               input logic [31:0] e_pc, input logic e_valid,
                               input logic [15:0] e_scnt, input logic [15:0] e_fcnt,
                               input logic e_to);
        total++;
        if (Instruction_out !== e_instr || PCPlus4_out !== e_pc || Valid_out !== e_valid ||
            StallCount !== e_scnt || FlushCount !== e_fcnt || StallTimeout !== e_to) begin
            bad++;
            $display("[TB] FAIL %s: got instr=%h pc=%h v=%b sc=%0d fc=%0d to=%b want instr=%h pc=%h v=%b sc=%0d fc=%0d to=%b",
                     name, Instruction_out, PCPlus4_out, Valid_out, StallCount, FlushCount,
                     StallTimeout, e_instr, e_pc, e_valid, e_scnt, e_fcnt, e_to);
        end
    endtask

    // Compare the narrow-counter instance's stall counter and watchdog.
    task automatic checkSmall(input string name, input logic [3:0] e_scnt, input logic e_to);
        total++;
        if (small_scnt !== e_scnt || small_to !== e_to) begin
            bad++;
            $display("[TB] FAIL %s: got sc=%h to=%b want sc=%h to=%b",
                     name, small_scnt, small_to, e_scnt, e_to);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;

        //              instr         pc            st    fl    exp_instr     exp_pc        v     sc  fc  to
        vecs[0] = '{32'h20020005, 32'h00000008, 1'b0, 1'b0, 32'h20020005, 32'h00000008, 1'b1, 16'd0, 16'd0, 1'b0};
        vecs[1] = '{32'h11111111, 32'h0000000C, 1'b1, 1'b0, 32'h20020005, 32'h00000008, 1'b1, 16'd1, 16'd0, 1'b0};
        vecs[2] = '{32'h22222222, 32'h00000010, 1'b1, 1'b0, 32'h20020005, 32'h00000008, 1'b1, 16'd2, 16'd0, 1'b0};
        vecs[3] = '{32'h33333333, 32'h00000014, 1'b1, 1'b0, 32'h20020005, 32'h00000008, 1'b1, 16'd3, 16'd0, 1'b0};
        vecs[4] = '{32'h44444444, 32'h00000010, 1'b1, 1'b1, NOP,          32'h00000010, 1'b0, 16'd3, 16'd1, 1'b0};
        vecs[5] = '{32'h55555555, 32'h00000018, 1'b1, 1'b0, NOP,          32'h00000010, 1'b0, 16'd4, 16'd1, 1'b0};
        vecs[6] = '{32'h8C010004, 32'h0000001C, 1'b0, 1'b0, 32'h8C010004, 32'h0000001C, 1'b1, 16'd4, 16'd1, 1'b0};
        vecs[7] = '{32'h66666666, 32'h00000020, 1'b0, 1'b1, NOP,          32'h00000020, 1'b0, 16'd4, 16'd2, 1'b0};
        vecs[8] = '{32'hAAAA0000, 32'h00000024, 1'b0, 1'b0, 32'hAAAA0000, 32'h00000024, 1'b1, 16'd4, 16'd2, 1'b0};

        Rst            = 1'b1;
        Instruction_in = 32'hDEADBEEF;
        PCPlus4_in     = 32'h00000004;
        Stall          = 1'b0;
        Flush          = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        checkOutput("reset_state", NOP, 32'h0, 1'b0, 16'd0, 16'd0, 1'b0);
        checkSmall("reset_state_small", 4'h0, 1'b0);
        Rst = 1'b0;

        $display("[TB] directed vector table");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].instr, vecs[i].pc, vecs[i].stall, vecs[i].flush);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_instr, vecs[i].exp_pc,
                        vecs[i].exp_valid, vecs[i].exp_scnt, vecs[i].exp_fcnt, vecs[i].exp_to);
        end

        $display("[TB] watchdog: runs broken by load or flush never time out");
        for (int i = 0; i < 7; i++) applyStimulus(32'hE0000000 + 32'(i), 32'h100, 1'b1, 1'b0);
        checkOutput("stall7_a", 32'hAAAA0000, 32'h24, 1'b1, 16'd11, 16'd2, 1'b0);
        applyStimulus(32'hBBBB0000, 32'h00000028, 1'b0, 1'b0);
        checkOutput("load_between", 32'hBBBB0000, 32'h28, 1'b1, 16'd11, 16'd2, 1'b0);
        for (int i = 0; i < 7; i++) applyStimulus(32'hE1000000 + 32'(i), 32'h200, 1'b1, 1'b0);
        checkOutput("stall7_b", 32'hBBBB0000, 32'h28, 1'b1, 16'd18, 16'd2, 1'b0);
        applyStimulus(32'h77777777, 32'h0000002C, 1'b1, 1'b1);
        checkOutput("flush_stall_break", NOP, 32'h2C, 1'b0, 16'd18, 16'd3, 1'b0);
        for (int i = 0; i < 7; i++) applyStimulus(32'hE2000000 + 32'(i), 32'h300, 1'b1, 1'b0);
        checkOutput("stall7_bubble", NOP, 32'h2C, 1'b0, 16'd25, 16'd3, 1'b0);

        $display("[TB] watchdog: eight consecutive stalls");
        applyStimulus(32'hCCCC0000, 32'h00000030, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) applyStimulus(32'hE3000000 + 32'(i), 32'h400, 1'b1, 1'b0);
        checkOutput("stall7_c", 32'hCCCC0000, 32'h30, 1'b1, 16'd32, 16'd3, 1'b0);
        applyStimulus(32'hE3000007, 32'h400, 1'b1, 1'b0);
        checkOutput("stall8_timeout", 32'hCCCC0000, 32'h30, 1'b1, 16'd33, 16'd3, 1'b1);
        applyStimulus(32'hDDDD0000, 32'h00000034, 1'b0, 1'b0);
        checkOutput("timeout_sticky", 32'hDDDD0000, 32'h34, 1'b1, 16'd33, 16'd3, 1'b1);

        $display("[TB] asynchronous reset mid-cycle");
        applyStimulus(32'h8C010004, 32'h00000038, 1'b0, 1'b0);
        checkOutput("preload", 32'h8C010004, 32'h38, 1'b1, 16'd33, 16'd3, 1'b1);
        #2;
        Rst = 1'b1;
        #1;
        checkOutput("async_reset", NOP, 32'h0, 1'b0, 16'd0, 16'd0, 1'b0);
        checkSmall("async_reset_small", 4'h0, 1'b0);
        @(negedge Clk);
        Rst = 1'b0;

        $display("[TB] stall counter saturation on the 4-bit instance");
        for (int i = 0; i < 15; i++) applyStimulus(32'hF0000000 + 32'(i), 32'h500, 1'b1, 1'b0);
        checkSmall("small_sc15", 4'hF, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(32'hF1000000 + 32'(i), 32'h600, 1'b1, 1'b0);
        checkSmall("small_sc20_saturated", 4'hF, 1'b1);
        checkOutput("wide_sc20", NOP, 32'h0, 1'b0, 16'd20, 16'd0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_id_pipe_reg.md
Name: if_id_pipe_reg

Overview:
IF/ID pipeline register for the pipelined MIPS core. It captures the fetched instruction and PC+4 each cycle and presents them to the decode stage. The stage is held when hazard logic raises Stall. It is squashed when the branch/jump OR term (Branch&Zero | Jump) raises Flush. Performance counters and a stall watchdog are included for debug and verification.

Parameters:
DATA_W, 32, width of instruction and PC fields
NOP_INSTR, 32'h00000000, instruction word inserted on flush/reset (sll $0,$0,0)
CNT_W, 16, width of stall/flush event counters
MAX_STALL, 8, consecutive stall cycles before StallTimeout asserts

Ports:
Clk  input  1  rising-edge clock
Rst  input  1  reset, asynchronous, active-high
Instruction_in  input  DATA_W  instruction from instruction memory
PCPlus4_in  input  DATA_W  PC+4 from fetch adder
Stall  input  1  hold current contents (load-use hazard)
Flush  input  1  squash current contents (branch taken / jump, from OR stage)
Instruction_out  output  DATA_W  registered instruction to decode
PCPlus4_out  output  DATA_W  registered PC+4 to decode
Valid_out  output  1  1 = Instruction_out is a real fetched instruction, 0 = bubble
StallCount  output  CNT_W  total cycles with Stall=1 and Flush=0
FlushCount  output  CNT_W  total cycles with Flush=1
StallTimeout  output  1  sticky: Stall held MAX_STALL consecutive cycles

Behaviour:
- Reset (Rst=1, async, any time including mid-stall): Instruction_out=NOP_INSTR, PCPlus4_out=0, Valid_out=0, StallCount=0, FlushCount=0, StallTimeout=0, internal run counter=0. Outputs change immediately, with no clock edge needed.
- All updates happen on the rising Clk edge when Rst=0. Latency is 1 cycle: a value on the input at edge N appears on the output after edge N.
- The register operates in three modes, evaluated per edge with priority Flush > Stall > Load:
  - FLUSH (Flush=1, Stall ignored): Instruction_out=NOP_INSTR, PCPlus4_out=PCPlus4_in, Valid_out=0. FlushCount increments. Run counter clears.
  - STALL (Stall=1, Flush=0): all data outputs and Valid_out hold. StallCount increments. Run counter increments, saturating at MAX_STALL.
  - LOAD (both 0): Instruction_out=Instruction_in, PCPlus4_out=PCPlus4_in, Valid_out=1. Run counter clears.
- StallTimeout sets on the edge where the run counter reaches MAX_STALL, i.e. the MAX_STALL-th consecutive stall edge. It stays set until Rst.
- StallCount and FlushCount saturate at all-ones and do not wrap.
- Simultaneous Flush and Stall are treated as FLUSH. Only FlushCount increments, and the run counter clears.
- A bubble held by Stall remains a bubble (Valid_out stays 0).
- Inputs are sampled only at the edge. There are no combinational paths from input to output.

Test Plan:
- Assert Rst mid-cycle with outputs loaded (Instruction_out=32'h8C010004) -> outputs immediately NOP/0/Valid 0, and counters are 0.
- Drive Instruction_in=32'h20020005, PCPlus4_in=32'h00000008 with Stall=Flush=0 -> after 1 edge, outputs match and Valid_out=1.
- Load 32'h20020005, then apply Stall=1 for 3 edges while changing the inputs -> outputs hold 32'h20020005, StallCount=3, StallTimeout=0.
- Apply Flush=1 and Stall=1 together with PCPlus4_in=32'h00000010 -> Instruction_out=NOP, PCPlus4_out=32'h10, Valid_out=0, FlushCount=1, StallCount unchanged.
- Apply Stall=1 for MAX_STALL=8 consecutive edges -> StallTimeout rises on the 8th edge and stays 1 after Stall drops. Apply Stall for 7 edges, then 1 load edge, then 7 more -> StallTimeout stays 0.
- Force StallCount to saturate with CNT_W=4 and 20 stall cycles -> StallCount=4'hF and does not wrap.
